// File: rtl/rpn_exec.sv
// rpn_exec - command sequencer for an RPN calculator sitting in front of a
// small operand stack. Each accepted command becomes a short burst of
// single-cycle pop/push strobes. The block keeps its own copy of the stack
// occupancy, so an illegal push or pop never reaches the stack.
//
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   cmd_valid    command offered
//   cmd_ready    command can be accepted (only while idle)
//   cmd_op       000 PUSH, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR,
//                110 DUP, 111 DROP
//   cmd_imm      immediate for PUSH
//   st_push      push strobe to the stack, st_wdata valid with it (else 0)
//   st_pop       pop strobe to the stack, st_rdata valid with it
//   st_rdata     current stack top
//   depth        tracked stack occupancy, 0..DEPTH
//   busy         sequencing a command
//   err/err_code last accepted command rejected: 01 underflow, 10 overflow
module rpn_exec #(
  parameter int DW    = 10,
  parameter int DEPTH = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_imm,
  output logic          st_push,
  output logic [DW-1:0] st_wdata,
  output logic          st_pop,
  input  logic [DW-1:0] st_rdata,
  output logic [2:0]    depth,
  output logic          busy,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_DUP  = 3'b110;
  localparam logic [2:0] OP_DROP = 3'b111;

  localparam logic [2:0] DEPTH_MAX = 3'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    POP_A,
    POP_B,
    WR1,
    WR2
  } state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q;

  logic is_binary;
  logic underflow;
  logic overflow;

  // B is the older operand (second pop), A the former top: SUB is B - A.
  function automatic logic [DW-1:0] alu(input logic [2:0]    op,
                                        input logic [DW-1:0] b,
                                        input logic [DW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = b + a;
      OP_SUB:  r = b - a;
      OP_AND:  r = b & a;
      OP_OR:   r = b | a;
      OP_XOR:  r = b ^ a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Legality of the offered command against the tracked depth. Only looked
  // at in IDLE; underflow wins over overflow when both could apply.
  always_comb begin
    is_binary = (cmd_op >= OP_ADD) && (cmd_op <= OP_XOR);
    underflow = (is_binary && (depth < 3'd2)) ||
                (((cmd_op == OP_DUP) || (cmd_op == OP_DROP)) && (depth == 3'd0));
    overflow  = ((cmd_op == OP_PUSH) || (cmd_op == OP_DUP)) && (depth >= DEPTH_MAX);
  end

  // Sequencer. Strobes and write data are registered together with the
  // state transition into the cycle that issues them, so nothing on cmd_*
  // reaches st_* combinationally. depth follows the strobes: it drops at the
  // edge ending a pop cycle and rises at the edge ending a push cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_PUSH;
      a_q       <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      st_push   <= 1'b0;
      st_pop    <= 1'b0;
      st_wdata  <= '0;
      depth     <= 3'd0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      st_push  <= 1'b0;
      st_pop   <= 1'b0;
      st_wdata <= '0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            err      <= 1'b0;
            err_code <= 2'b00;
            if (underflow) begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end else if (overflow) begin
              err      <= 1'b1;
              err_code <= 2'b10;
            end else if (cmd_op == OP_PUSH) begin
              state     <= WR1;
              st_push   <= 1'b1;
              st_wdata  <= cmd_imm;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              state     <= POP_A;
              st_pop    <= 1'b1;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        POP_A: begin
          a_q   <= st_rdata;
          depth <= depth - 3'd1;
          if (op_q == OP_DROP) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (op_q == OP_DUP) begin
            state    <= WR1;
            st_push  <= 1'b1;
            st_wdata <= st_rdata;
          end else begin
            state  <= POP_B;
            st_pop <= 1'b1;
          end
        end
        POP_B: begin
          depth    <= depth - 3'd1;
          state    <= WR1;
          st_push  <= 1'b1;
          st_wdata <= alu(op_q, st_rdata, a_q);
        end
        WR1: begin
          depth <= depth + 3'd1;
          if (op_q == OP_DUP) begin
            state    <= WR2;
            st_push  <= 1'b1;
            st_wdata <= a_q;
          end else begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        WR2: begin
          depth     <= depth + 3'd1;
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_exec.sv
// tb_rpn_exec - self-checking bench for rpn_exec. A small behavioural stack
// answers the pop port; every expected push value is queued when the
// command is issued and compared when st_push appears.
module tb_rpn_exec;

  localparam int DW = 10;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_DUP  = 3'b110;
  localparam logic [2:0] OP_DROP = 3'b111;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_imm;
  logic          st_push;
  logic [DW-1:0] st_wdata;
  logic          st_pop;
  logic [DW-1:0] st_rdata;
  logic [2:0]    depth;
  logic          busy;
  logic          err;
  logic [1:0]    err_code;

  int testCount = 0;
  int failCount = 0;

  logic [DW-1:0] expQ[$];

  logic [DW-1:0] stackMem [0:7];
  logic [3:0]    sp;

  rpn_exec #(.DW(DW), .DEPTH(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_imm   (cmd_imm),
    .st_push   (st_push),
    .st_wdata  (st_wdata),
    .st_pop    (st_pop),
    .st_rdata  (st_rdata),
    .depth     (depth),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // Behavioural operand stack driven by the DUT strobes
  assign st_rdata = (sp != 4'd0) ? stackMem[3'(sp - 4'd1)] : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 4'd0;
    end else if (st_push && (sp < 4'd8)) begin
      stackMem[sp[2:0]] <= st_wdata;
      sp <= sp + 4'd1;
    end else if (st_pop && (sp != 4'd0)) begin
      sp <= sp - 4'd1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (st_push) begin
        if (expQ.size() == 0)
          checkOutput("push_expected", 32'(expQ.size()), 32'd1);
        else
          checkOutput("push_data", 32'(st_wdata), 32'(expQ.pop_front()));
      end else begin
        checkOutput("wdata_zero", 32'(st_wdata), 32'd0);
      end
      checkOutput("push_pop_excl", 32'(st_push & st_pop), 32'd0);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int waited = 0;
    while (!cmd_ready && waited < 20) begin
      nextCycle();
      waited++;
    end
    checkOutput("idle_reached", 32'(cmd_ready), 32'd1);
  endtask

  // Offers one command and returns 1 time unit after the edge that accepts it
  task automatic applyStimulus(input logic [2:0] op, input logic [DW-1:0] imm);
    waitIdle();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    nextCycle();
    cmd_valid = 1'b0;
  endtask

  task automatic doReset();
    cmd_valid = 1'b0;
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    expQ.delete();
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = OP_PUSH;
    cmd_imm = '0;
    nextCycle();

    // Reset values
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_push", 32'(st_push), 32'd0);
    checkOutput("rst_pop", 32'(st_pop), 32'd0);
    checkOutput("rst_wdata", 32'(st_wdata), 32'd0);
    checkOutput("rst_depth", 32'(depth), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_errcode", 32'(err_code), 32'd0);
    doReset();

    // PUSH 5, PUSH 3, SUB: depth 1, 2, 1, 0, 1 and result 2
    expQ.push_back(10'd5);
    applyStimulus(OP_PUSH, 10'd5);
    checkOutput("push_strobe", 32'(st_push), 32'd1);
    checkOutput("push_busy", 32'(busy), 32'd1);
    nextCycle();
    checkOutput("d_after_p5", 32'(depth), 32'd1);
    expQ.push_back(10'd3);
    applyStimulus(OP_PUSH, 10'd3);
    nextCycle();
    checkOutput("d_after_p3", 32'(depth), 32'd2);
    expQ.push_back(10'd2);
    applyStimulus(OP_SUB, 10'd0);
    checkOutput("sub_popa", 32'(st_pop), 32'd1);
    nextCycle();
    checkOutput("sub_popb", 32'(st_pop), 32'd1);
    checkOutput("sub_d1", 32'(depth), 32'd1);
    nextCycle();
    checkOutput("sub_wr", 32'(st_push), 32'd1);
    checkOutput("sub_d0", 32'(depth), 32'd0);
    nextCycle();
    checkOutput("sub_ready", 32'(cmd_ready), 32'd1);
    checkOutput("sub_d_end", 32'(depth), 32'd1);

    // Wrap: 1023 + 2 = 1; a PUSH held while busy must wait, then 0 - 1 = 1023
    expQ.push_back(10'd1023);
    applyStimulus(OP_PUSH, 10'd1023);
    expQ.push_back(10'd2);
    applyStimulus(OP_PUSH, 10'd2);
    expQ.push_back(10'd1);
    applyStimulus(OP_ADD, 10'd0);
    expQ.push_back(10'd0);
    cmd_valid = 1'b1;
    cmd_op    = OP_PUSH;
    cmd_imm   = 10'd0;
    nextCycle();
    checkOutput("held_popb", 32'(st_pop), 32'd1);
    nextCycle();
    checkOutput("held_wr_busy", 32'(busy), 32'd1);
    nextCycle();
    checkOutput("held_idle", 32'(cmd_ready), 32'd1);
    nextCycle();
    cmd_valid = 1'b0;
    checkOutput("held_push", 32'(st_push), 32'd1);
    expQ.push_back(10'd1);
    applyStimulus(OP_PUSH, 10'd1);
    expQ.push_back(10'd1023);
    applyStimulus(OP_SUB, 10'd0);
    waitIdle();
    checkOutput("wrap_depth", 32'(depth), 32'd3);

    // Logic ops
    doReset();
    expQ.push_back(10'h3CC);
    applyStimulus(OP_PUSH, 10'h3CC);
    expQ.push_back(10'h2A5);
    applyStimulus(OP_PUSH, 10'h2A5);
    expQ.push_back(10'h169);
    applyStimulus(OP_XOR, 10'd0);
    expQ.push_back(10'h0F0);
    applyStimulus(OP_PUSH, 10'h0F0);
    expQ.push_back(10'h060);
    applyStimulus(OP_AND, 10'd0);
    expQ.push_back(10'h301);
    applyStimulus(OP_PUSH, 10'h301);
    expQ.push_back(10'h361);
    applyStimulus(OP_OR, 10'd0);
    waitIdle();
    checkOutput("logic_depth", 32'(depth), 32'd1);

    // DUP: one pop, two pushes of 9, ready low for 3 cycles
    doReset();
    expQ.push_back(10'd9);
    applyStimulus(OP_PUSH, 10'd9);
    expQ.push_back(10'd9);
    expQ.push_back(10'd9);
    applyStimulus(OP_DUP, 10'd0);
    checkOutput("dup_pop", 32'(st_pop), 32'd1);
    checkOutput("dup_rdy1", 32'(cmd_ready), 32'd0);
    nextCycle();
    checkOutput("dup_push1", 32'(st_push), 32'd1);
    checkOutput("dup_rdy2", 32'(cmd_ready), 32'd0);
    nextCycle();
    checkOutput("dup_push2", 32'(st_push), 32'd1);
    checkOutput("dup_rdy3", 32'(cmd_ready), 32'd0);
    nextCycle();
    checkOutput("dup_rdy4", 32'(cmd_ready), 32'd1);
    checkOutput("dup_depth", 32'(depth), 32'd2);

    // Underflow: ADD with depth 1 is rejected, next PUSH clears err
    doReset();
    expQ.push_back(10'd7);
    applyStimulus(OP_PUSH, 10'd7);
    applyStimulus(OP_ADD, 10'd0);
    checkOutput("uf_err", 32'(err), 32'd1);
    checkOutput("uf_code", 32'(err_code), 32'd1);
    checkOutput("uf_pop", 32'(st_pop), 32'd0);
    checkOutput("uf_ready", 32'(cmd_ready), 32'd1);
    checkOutput("uf_depth", 32'(depth), 32'd1);
    nextCycle();
    checkOutput("uf_hold", 32'(err), 32'd1);
    expQ.push_back(10'd4);
    applyStimulus(OP_PUSH, 10'd4);
    checkOutput("uf_clear", 32'(err), 32'd0);
    waitIdle();
    checkOutput("uf_depth2", 32'(depth), 32'd2);

    // Overflow: fill to 7, PUSH and DUP rejected, DROP then leaves 6
    doReset();
    for (int i = 0; i < 7; i++) begin
      expQ.push_back(10'(10 + i));
      applyStimulus(OP_PUSH, 10'(10 + i));
    end
    waitIdle();
    checkOutput("of_full", 32'(depth), 32'd7);
    applyStimulus(OP_PUSH, 10'd99);
    checkOutput("of_push_code", 32'(err_code), 32'd2);
    checkOutput("of_push_strobe", 32'(st_push), 32'd0);
    applyStimulus(OP_DUP, 10'd0);
    checkOutput("of_dup_code", 32'(err_code), 32'd2);
    checkOutput("of_dup_pop", 32'(st_pop), 32'd0);
    checkOutput("of_depth", 32'(depth), 32'd7);
    applyStimulus(OP_DROP, 10'd0);
    checkOutput("drop_pop", 32'(st_pop), 32'd1);
    checkOutput("drop_err", 32'(err), 32'd0);
    nextCycle();
    checkOutput("drop_ready", 32'(cmd_ready), 32'd1);
    checkOutput("drop_depth", 32'(depth), 32'd6);

    // Reset during POP_B of an ADD abandons it
    doReset();
    expQ.push_back(10'd1);
    applyStimulus(OP_PUSH, 10'd1);
    expQ.push_back(10'd2);
    applyStimulus(OP_PUSH, 10'd2);
    applyStimulus(OP_ADD, 10'd0);
    nextCycle();
    checkOutput("abort_popb", 32'(st_pop), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(cmd_ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_pop", 32'(st_pop), 32'd0);
    checkOutput("abort_push", 32'(st_push), 32'd0);
    checkOutput("abort_depth", 32'(depth), 32'd0);
    nextCycle();
    rst = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("abort_quiet", 32'(st_push), 32'd0);

    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/rpn_exec.md
# rpn_exec

Command sequencer that sits directly upstream of the 7-entry operand stack and turns a stream of RPN-calculator commands into single-cycle push/pop strobes on that stack. It reads operands through the stack's pop port, performs arithmetic or logic on them, and pushes results back. It also tracks stack depth itself so that no illegal push or pop ever reaches the stack.

## Interface
Parameters:
- DW, 10, data width of stack entries and immediates
- DEPTH, 7, stack capacity in entries

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_op  in  3  opcode: 000 PUSH, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 DUP, 111 DROP
- cmd_imm  in  DW  immediate, used by PUSH only
- st_push  out  1  one-cycle push strobe to stack
- st_wdata  out  DW  push data, valid while st_push=1, otherwise 0
- st_pop  out  1  one-cycle pop strobe to stack
- st_rdata  in  DW  stack top, valid combinationally during a st_pop cycle
- depth  out  3  current stack occupancy, 0..DEPTH
- busy  out  1  high in any state other than IDLE
- err  out  1  last accepted command was rejected
- err_code  out  2  00 none, 01 underflow, 10 overflow

## Operation
- States: IDLE, POP_A, POP_B, WR1, WR2.
- A command is accepted on a clock edge where cmd_valid & cmd_ready. The block latches cmd_op and cmd_imm, clears err/err_code, then checks legality against depth:
  - Binary ops (ADD..XOR) need depth ≥ 2.
  - DUP needs 1 ≤ depth ≤ DEPTH-1.
  - DROP needs depth ≥ 1.
  - PUSH needs depth ≤ DEPTH-1.
- Illegal command: the block stays in IDLE and sets err=1 with err_code. Underflow (01) takes priority over overflow (10). No stack strobe is issued and depth is unchanged.
- Legal command sequences:
  - PUSH: IDLE → WR1 (st_push, st_wdata=imm) → IDLE.
  - Binary: IDLE → POP_A (st_pop; capture A=st_rdata, the top) → POP_B (st_pop; capture B=st_rdata) → WR1 (st_push, st_wdata = B op A) → IDLE.
  - DUP: IDLE → POP_A (capture A) → WR1 (push A) → WR2 (push A) → IDLE.
  - DROP: IDLE → POP_A (st_pop, value discarded) → IDLE.
- Arithmetic: SUB = B − A, so the older operand minus the top. ADD and SUB wrap modulo 2^DW with no carry or borrow flag. AND, OR and XOR are bitwise.
- depth changes by −1 on every st_pop cycle and by +1 on every st_push cycle. It never leaves the range 0..DEPTH.
- st_push and st_pop are never asserted in the same cycle.
- err/err_code hold until the next accepted command.
- cmd_valid, cmd_op and cmd_imm are ignored while busy. A command offered while busy is not lost; it waits for cmd_ready.

## Timing
- Reset values: state IDLE, cmd_ready=1, busy=0, st_push=0, st_pop=0, st_wdata=0, depth=0, err=0, err_code=00, operand registers 0.
- rst asserted mid-command abandons the command immediately. The stack is reset by the same rst, so depth=0 is consistent.
- Latency from accept edge to first strobe: 1 cycle.
- Command occupancy, including the return to IDLE: PUSH 2 cycles, DROP 2, binary 4, DUP 4. Rejected commands take 1 cycle.
- Back-to-back throughput: cmd_ready rises in the cycle after the last strobe.
- All outputs are registered or decoded from state plus registered operands. There is no combinational path from cmd_* to st_*. st_rdata is sampled on the clock edge that ends each pop cycle.

## Test plan
- After reset, PUSH 5, PUSH 3, SUB → st_pop in 2 consecutive cycles, then st_push with st_wdata=2; depth goes 1, 2, 1, 0, 1.
- PUSH 1023, PUSH 2, ADD → st_wdata=1 (wrap); PUSH 0, PUSH 1, SUB → st_wdata=1023.
- PUSH 9, DUP → one st_pop, then two consecutive st_push of 9; final depth=2; cmd_ready low for 3 cycles after accept.
- Underflow: depth=1, ADD → no strobes, err=1, err_code=01, depth stays 1. The next legal PUSH clears err.
- Overflow: 7 PUSHes (depth=7), then PUSH or DUP → err_code=10, no st_push. DROP afterwards → depth=6.
- Assert rst during POP_B of an ADD → next cycle: state IDLE, all strobes 0, depth=0, cmd_ready=1.
